// File: rtl/occupancy_counter.sv
// Gate occupancy counter: two-beam direction decoder with a saturating count.
// clk/reset_n; sensor_a/b raw beams; count, enter/exit pulses, full/empty.
module occupancy_counter #(
  parameter int unsigned MAX = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [5:0] count,
  output logic       enter,
  output logic       exit,
  output logic       full,
  output logic       empty
);

  localparam logic [5:0] CMAX = 6'(MAX);

  typedef enum logic [2:0] {
    IDLE, IN1, IN2, IN3,
    OUT1, OUT2, OUT3, WAIT
  } state_t;

  state_t     state;
  logic [1:0] a_q;
  logic [1:0] b_q;
  logic [1:0] ab;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= {a_q[0], sensor_a};
      b_q <= {b_q[0], sensor_b};
    end
  end

  assign ab = {a_q[1], b_q[1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      enter <= 1'b0;
      exit  <= 1'b0;
    end else begin
      enter <= 1'b0;
      exit  <= 1'b0;
      unique case (state)
        IDLE: unique case (ab)
          2'b10: state <= IN1;
          2'b01: state <= OUT1;
          2'b11: state <= WAIT;
          default: state <= IDLE;
        endcase
        IN1: unique case (ab)
          2'b11: state <= IN2;
          2'b00: state <= IDLE;
          2'b10: state <= IN1;
          default: state <= WAIT;
        endcase
        IN2: unique case (ab)
          2'b01: state <= IN3;
          2'b10: state <= IN1;
          2'b11: state <= IN2;
          default: state <= WAIT;
        endcase
        IN3: unique case (ab)
          2'b00: begin
            state <= IDLE;
            enter <= 1'b1;
            if (count < CMAX)
              count <= count + 6'd1;
          end
          2'b11: state <= IN2;
          2'b01: state <= IN3;
          default: state <= WAIT;
        endcase
        OUT1: unique case (ab)
          2'b11: state <= OUT2;
          2'b00: state <= IDLE;
          2'b01: state <= OUT1;
          default: state <= WAIT;
        endcase
        OUT2: unique case (ab)
          2'b10: state <= OUT3;
          2'b01: state <= OUT1;
          2'b11: state <= OUT2;
          default: state <= WAIT;
        endcase
        OUT3: unique case (ab)
          2'b00: begin
            state <= IDLE;
            exit  <= 1'b1;
            if (count != 6'd0)
              count <= count - 6'd1;
          end
          2'b11: state <= OUT2;
          2'b10: state <= OUT3;
          default: state <= WAIT;
        endcase
        WAIT: begin
          if (ab == 2'b00)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full  = (count == CMAX);
  assign empty = (count == 6'd0);

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench for occupancy_counter.
// Table of gate passes plus saturation and mid-pass reset sequences.
module tb_occupancy_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sensor_a = 1'b0;
  logic       sensor_b = 1'b0;
  logic [5:0] count;
  logic       enter;
  logic       exit;
  logic       full;
  logic       empty;

  int errors = 0;
  int checks = 0;
  int ent_n = 0;
  int ext_n = 0;

  always #5 clk = ~clk;

  occupancy_counter #(.MAX(25)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .count(count),
    .enter(enter),
    .exit(exit),
    .full(full),
    .empty(empty)
  );

  always @(negedge clk) begin
    if (enter === 1'b1) ent_n++;
    if (exit === 1'b1) ext_n++;
    if (enter === 1'b1 && exit === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL overlap: enter and exit both high at %0t", $time);
    end
  end

  typedef struct {
    string      nm;
    logic [5:0] cnt;
    int         ent;
    int         ext;
  } exp_t;

  typedef struct {
    string      nm;
    logic [9:0] seq;
    int         n;
    logic [5:0] cnt;
    int         ent;
    int         ext;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];

  localparam logic [9:0] P_IN    = {2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
  localparam logic [9:0] P_OUT   = {2'b00, 2'b00, 2'b10, 2'b11, 2'b01};
  localparam logic [9:0] P_ABORT = {2'b00, 2'b00, 2'b10, 2'b11, 2'b10};
  localparam logic [9:0] P_JUMP  = {2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  localparam logic [9:0] P_BACK  = {2'b00, 2'b00, 2'b01, 2'b11, 2'b01};
  localparam logic [9:0] P_BOTH  = {2'b00, 2'b00, 2'b00, 2'b00, 2'b11};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ab, input int cyc);
    @(posedge clk);
    #1;
    {sensor_a, sensor_b} = ab;
    repeat (cyc - 1) @(posedge clk);
  endtask

  task automatic start_obs(input string nm, input logic [5:0] cnt,
                           input int ent, input int ext);
    exp_t e;
    @(posedge clk);
    #1;
    ent_n = 0;
    ext_n = 0;
    e.nm  = nm;
    e.cnt = cnt;
    e.ent = ent;
    e.ext = ext;
    sb.push_back(e);
  endtask

  task automatic end_obs();
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue");
    end else begin
      e = sb.pop_front();
      chk({e.nm, " count"}, 32'(count), 32'(e.cnt));
      chk({e.nm, " enter"}, ent_n, e.ent);
      chk({e.nm, " exit"}, ext_n, e.ext);
      chk({e.nm, " full"}, 32'(full), 32'(e.cnt == 6'd25));
      chk({e.nm, " empty"}, 32'(empty), 32'(e.cnt == 6'd0));
    end
  endtask

  task automatic run_seq(input string nm, input logic [9:0] seq,
                         input int n, input logic [5:0] cnt,
                         input int ent, input int ext);
    start_obs(nm, cnt, ent, ext);
    for (int i = 0; i < n; i++)
      drive(seq[2*i +: 2], 4);
    end_obs();
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    {sensor_a, sensor_b} = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{"in_1",     P_IN,    4, 6'd1, 1, 0};
    tbl[1] = '{"in_2",     P_IN,    4, 6'd2, 1, 0};
    tbl[2] = '{"in_3",     P_IN,    4, 6'd3, 1, 0};
    tbl[3] = '{"out_1",    P_OUT,   4, 6'd2, 0, 1};
    tbl[4] = '{"abort_in", P_ABORT, 4, 6'd2, 0, 0};
    tbl[5] = '{"jump",     P_JUMP,  3, 6'd2, 0, 0};
    tbl[6] = '{"in_after", P_IN,    4, 6'd3, 1, 0};
    tbl[7] = '{"back_out", P_BACK,  4, 6'd3, 0, 0};
    tbl[8] = '{"both_on",  P_BOTH,  2, 6'd3, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst enter", 32'(enter), 0);
    chk("rst exit", 32'(exit), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle count", 32'(count), 0);
    chk("idle empty", 32'(empty), 1);

    for (int i = 0; i < 9; i++)
      run_seq(tbl[i].nm, tbl[i].seq, tbl[i].n,
              tbl[i].cnt, tbl[i].ent, tbl[i].ext);

    do_reset();
    for (int i = 1; i <= 26; i++)
      run_seq("sat_in", P_IN, 4, (i > 25) ? 6'd25 : 6'(i), 1, 0);
    for (int i = 24; i >= 0; i--)
      run_seq("sat_out", P_OUT, 4, 6'(i), 0, 1);
    run_seq("out_at_0", P_OUT, 4, 6'd0, 0, 1);

    do_reset();
    for (int i = 1; i <= 7; i++)
      run_seq("pre_rst", P_IN, 4, 6'(i), 1, 0);
    drive(2'b10, 4);
    drive(2'b11, 4);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async rst count", 32'(count), 0);
    chk("async rst empty", 32'(empty), 1);
    chk("async rst full", 32'(full), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    start_obs("rst_wait", 6'd0, 0, 0);
    repeat (6) @(posedge clk);
    drive(2'b01, 4);
    drive(2'b00, 4);
    end_obs();
    run_seq("post_rst_in", P_IN, 4, 6'd1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
